// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: a shadow pipeline of in-flight destinations produces
// EX operand forward selects and an ID stall request for late results and a busy MULT/DIV unit.
module hazard_forward_ctrl #(
    parameter int DEPTH      = 3,
    parameter int REG_W      = 5,
    parameter int RDY_W      = 2,
    parameter int MD_LATENCY = 32,
    parameter int SEL_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic [RDY_W-1:0] id_rdy_stage,
    input  logic             id_md_start,
    input  logic             id_hilo_rd,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_a,
    output logic [SEL_W-1:0] fwd_b,
    output logic             md_busy
);
    localparam int MD_W = $clog2(MD_LATENCY + 1);

    // wr_reg folds valid, regwrite and dest!=0 together, so r0 can never match.
    logic [DEPTH-1:0] wr_reg;
    logic [REG_W-1:0] dest_reg [DEPTH];
    logic [RDY_W-1:0] rdy_reg  [DEPTH-1];
    // Source fields only matter while the instruction sits in EX.
    logic [REG_W-1:0] ex_rs_reg;
    logic [REG_W-1:0] ex_rt_reg;
    logic             ex_use_rs_reg;
    logic             ex_use_rt_reg;
    logic [MD_W-1:0]  md_cnt_reg;

    logic             advance;
    logic             data_stall;
    logic             md_stall;
    logic             stall_a;
    logic             stall_b;
    logic [DEPTH-1:1] fa_match;
    logic [DEPTH-1:1] fb_match;
    logic [DEPTH-2:0] sa_match;
    logic [DEPTH-2:0] sb_match;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_fwd_match
            assign fa_match[gi] = wr_reg[gi] && (dest_reg[gi] == ex_rs_reg);
            assign fb_match[gi] = wr_reg[gi] && (dest_reg[gi] == ex_rt_reg);
        end
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_stall_match
            assign sa_match[gi] = wr_reg[gi] && (dest_reg[gi] == id_rs);
            assign sb_match[gi] = wr_reg[gi] && (dest_reg[gi] == id_rt);
        end
    endgenerate

    // Scanning oldest to youngest lets the youngest producer win.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int j = DEPTH - 1; j >= 1; j--) begin
            if (ex_use_rs_reg && fa_match[j]) fwd_a = SEL_W'(j);
            if (ex_use_rt_reg && fb_match[j]) fwd_b = SEL_W'(j);
        end
    end

    // A producer in slot k reaches slot k+1 by the time ID enters EX.
    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (sa_match[k]) stall_a = (k + 1 <= int'(rdy_reg[k]));
            if (sb_match[k]) stall_b = (k + 1 <= int'(rdy_reg[k]));
        end
        data_stall = (id_use_rs & stall_a) | (id_use_rt & stall_b);
    end

    assign md_busy  = (md_cnt_reg != '0);
    assign md_stall = (id_hilo_rd | id_md_start) & md_busy;
    assign stall    = id_valid & ~flush & (data_stall | md_stall);
    assign advance  = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_reg        <= '0;
            ex_rs_reg     <= '0;
            ex_rt_reg     <= '0;
            ex_use_rs_reg <= 1'b0;
            ex_use_rt_reg <= 1'b0;
            for (int k = 0; k < DEPTH; k++) dest_reg[k] <= '0;
            for (int k = 0; k < DEPTH - 1; k++) rdy_reg[k] <= '0;
        end else begin
            wr_reg        <= {wr_reg[DEPTH-2:0], advance & id_regwrite & (id_dest != '0)};
            ex_rs_reg     <= id_rs;
            ex_rt_reg     <= id_rt;
            ex_use_rs_reg <= advance & id_use_rs;
            ex_use_rt_reg <= advance & id_use_rt;
            dest_reg[0]   <= id_dest;
            rdy_reg[0]    <= id_rdy_stage;
            for (int k = 1; k < DEPTH; k++) dest_reg[k] <= dest_reg[k-1];
            for (int k = 1; k < DEPTH - 1; k++) rdy_reg[k] <= rdy_reg[k-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_reg <= '0;
        end else if (advance && id_md_start) begin
            md_cnt_reg <= MD_W'(MD_LATENCY);
        end else if (md_cnt_reg != '0) begin
            md_cnt_reg <= md_cnt_reg - MD_W'(1);
        end
    end
endmodule
